sgf_mult_round_norm: RTL

- Stage directly downstream of the Karatsuba significand multiplier (csubRecursiveKOA) in the FPU multiply path.
- Takes the raw 2*SW-bit significand product plus the precomputed biased exponent and sign.
- Normalizes, rounds under four IEEE-754 modes, and adjusts the exponent.
- Flags overflow, underflow and inexact results; a 2-stage valid/ready pipeline with full throughput.

---
 rtl/sgf_mult_round_norm_pkg.sv | 17 +
 rtl/sgf_mult_round_norm_if.sv | 36 +++
 rtl/sgf_mult_round_norm_round_decision.sv | 27 ++
 rtl/sgf_mult_round_norm.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sgf_mult_round_norm_pkg.sv
// Shared definitions for the FPU multiply path: rounding-mode encodings and
// the significand/exponent widths of the single and double builds.
package sgf_mult_round_norm_pkg;

  typedef enum logic [1:0] {
    RM_RNE  = 2'b00,
    RM_RTZ  = 2'b01,
    RM_PINF = 2'b10,
    RM_NINF = 2'b11
  } rmode_e;

  localparam int SW_SINGLE = 24;
  localparam int EW_SINGLE = 8;
  localparam int SW_DOUBLE = 53;
  localparam int EW_DOUBLE = 11;

endpackage

// File: rtl/sgf_mult_round_norm_if.sv
// Beat-level bus of the multiply round/normalize stage: input product beat
// from the significand multiplier and the rounded result toward the packer.
interface sgf_mult_round_norm_if #(
  parameter int SW = 24,
  parameter int EW = 8
) ();

  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [2*SW-1:0]      Data_S_i;
  logic signed [EW+1:0] Exp_i;
  logic                 Sign_i;
  logic [1:0]           Rmode_i;

  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [SW-2:0]        Sgf_o;
  logic [EW-1:0]        Exp_o;
  logic                 Sign_o;
  logic                 Overflow_o;
  logic                 Underflow_o;
  logic                 Inexact_o;

  modport slave (
    input  in_valid_i, Data_S_i, Exp_i, Sign_i, Rmode_i, out_ready_i,
    output in_ready_o, out_valid_o, Sgf_o, Exp_o, Sign_o,
           Overflow_o, Underflow_o, Inexact_o
  );

  modport master (
    output in_valid_i, Data_S_i, Exp_i, Sign_i, Rmode_i, out_ready_i,
    input  in_ready_o, out_valid_o, Sgf_o, Exp_o, Sign_o,
           Overflow_o, Underflow_o, Inexact_o
  );

endinterface

// File: rtl/sgf_mult_round_norm_round_decision.sv
// Combinational IEEE-754 rounding decision from guard/sticky/lsb and sign;
// shared by the multiplier and adder rounding stages.
module sgf_mult_round_norm_round_decision
  import sgf_mult_round_norm_pkg::*;
(
  input  logic   g_i,
  input  logic   s_i,
  input  logic   lsb_i,
  input  logic   sign_i,
  input  rmode_e rmode_i,
  output logic   inc_o,
  output logic   inexact_o
);

  always_comb begin
    inexact_o = g_i | s_i;
    inc_o     = 1'b0;
    case (rmode_i)
      RM_RNE:  inc_o = g_i & (s_i | lsb_i);
      RM_RTZ:  inc_o = 1'b0;
      RM_PINF: inc_o = (g_i | s_i) & ~sign_i;
      RM_NINF: inc_o = (g_i | s_i) & sign_i;
      default: inc_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/sgf_mult_round_norm.sv
// Two-stage normalize/round stage after the significand multiplier: stage 1
// aligns the product, stage 2 rounds and applies exponent range checks.
module sgf_mult_round_norm
  import sgf_mult_round_norm_pkg::*;
#(
  parameter int SW = 24,
  parameter int EW = 8
) (
  input logic clk,
  input logic rst,
  sgf_mult_round_norm_if.slave bus
);

  localparam logic signed [EW+1:0] EXP_ONE  = (EW+2)'(1);
  localparam logic signed [EW+1:0] EXP_ZERO = (EW+2)'(0);
  localparam logic signed [EW+1:0] EXP_MAX  = (EW+2)'((1 << EW) - 1);

  // Handshake: a beat moves on a rising edge when valid & ready are both high.
  // Each stage advances when it is empty or its successor advances, so both
  // stages can shift together and the block sustains one beat per cycle.
  logic s2_adv, s1_adv;

  logic                 s1_valid_q;
  logic [SW-2:0]        s1_frac_q,  s1_frac_d;
  logic                 s1_g_q,     s1_g_d;
  logic                 s1_s_q,     s1_s_d;
  logic signed [EW+1:0] s1_exp_q,   s1_exp_d;
  logic                 s1_sign_q;
  rmode_e               s1_rmode_q;
  logic                 s1_zero_q,  s1_zero_d;

  logic                 s2_valid_q;
  logic [SW-2:0]        sgf_q,  sgf_d;
  logic [EW-1:0]        expo_q, expo_d;
  logic                 sign_q;
  logic                 ovf_q,  ovf_d;
  logic                 unf_q,  unf_d;
  logic                 inx_q,  inx_d;

  logic                 inc, inexact, carry;
  logic [SW-2:0]        frac_rnd;
  logic signed [EW+1:0] exp_rnd;

  assign s2_adv         = ~s2_valid_q | bus.out_ready_i;
  assign s1_adv         = ~s1_valid_q | s2_adv;
  assign bus.in_ready_o = s1_adv;

  always_comb begin
    s1_zero_d = ~|bus.Data_S_i;
    if (bus.Data_S_i[2*SW-1]) begin
      s1_frac_d = bus.Data_S_i[2*SW-2:SW];
      s1_g_d    = bus.Data_S_i[SW-1];
      s1_s_d    = |bus.Data_S_i[SW-2:0];
      s1_exp_d  = bus.Exp_i + EXP_ONE;
    end else begin
      s1_frac_d = bus.Data_S_i[2*SW-3:SW-1];
      s1_g_d    = bus.Data_S_i[SW-2];
      s1_s_d    = |bus.Data_S_i[SW-3:0];
      s1_exp_d  = bus.Exp_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_frac_q  <= '0;
      s1_g_q     <= 1'b0;
      s1_s_q     <= 1'b0;
      s1_exp_q   <= '0;
      s1_sign_q  <= 1'b0;
      s1_rmode_q <= RM_RNE;
      s1_zero_q  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= bus.in_valid_i;
      if (bus.in_valid_i) begin
        s1_frac_q  <= s1_frac_d;
        s1_g_q     <= s1_g_d;
        s1_s_q     <= s1_s_d;
        s1_exp_q   <= s1_exp_d;
        s1_sign_q  <= bus.Sign_i;
        s1_rmode_q <= rmode_e'(bus.Rmode_i);
        s1_zero_q  <= s1_zero_d;
      end
    end
  end

  sgf_mult_round_norm_round_decision u_round_decision (
    .g_i       (s1_g_q),
    .s_i       (s1_s_q),
    .lsb_i     (s1_frac_q[0]),
    .sign_i    (s1_sign_q),
    .rmode_i   (s1_rmode_q),
    .inc_o     (inc),
    .inexact_o (inexact)
  );

  // An all-ones fraction that rounds up wraps to zero and bumps the exponent.
  assign carry    = inc & (&s1_frac_q);
  assign frac_rnd = s1_frac_q + {{(SW-2){1'b0}}, inc};
  assign exp_rnd  = s1_exp_q + {{(EW+1){1'b0}}, carry};

  always_comb begin
    sgf_d  = frac_rnd;
    expo_d = exp_rnd[EW-1:0];
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    inx_d  = inexact;
    if (s1_zero_q) begin
      sgf_d  = '0;
      expo_d = '0;
      inx_d  = 1'b0;
    end else if (exp_rnd >= EXP_MAX) begin
      sgf_d  = '0;
      expo_d = '1;
      ovf_d  = 1'b1;
      inx_d  = 1'b1;
    end else if (exp_rnd <= EXP_ZERO) begin
      sgf_d  = '0;
      expo_d = '0;
      unf_d  = 1'b1;
      inx_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q <= 1'b0;
      sgf_q      <= '0;
      expo_q     <= '0;
      sign_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      inx_q      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sgf_q  <= sgf_d;
        expo_q <= expo_d;
        sign_q <= s1_sign_q;
        ovf_q  <= ovf_d;
        unf_q  <= unf_d;
        inx_q  <= inx_d;
      end
    end
  end

  assign bus.out_valid_o = s2_valid_q;
  assign bus.Sgf_o       = sgf_q;
  assign bus.Exp_o       = expo_q;
  assign bus.Sign_o      = sign_q;
  assign bus.Overflow_o  = ovf_q;
  assign bus.Underflow_o = unf_q;
  assign bus.Inexact_o   = inx_q;

endmodule
